vga_stream_sink: RTL

VGA_STREAM_SINK -- requirements
Module: vga_stream_sink

---
 rtl/vga_stream_sink.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/vga_stream_sink.sv
// Avalon-ST pixel sink: captures a quantised 3-bit RGB frame into RAM and tracks framing.
// Optional running frame checksum is built only when FRAME_CHECKSUM_EN is defined.
module vga_stream_sink #(
    parameter int WIDTH = 640,
    parameter int HEIGHT = 480,
    localparam int NumPixels = WIDTH * HEIGHT,
    localparam int AW = (NumPixels > 1) ? $clog2(NumPixels) : 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [29:0]   data,
    input  logic          startofpacket,
    input  logic          endofpacket,
    input  logic          valid,
    output logic          ready,
    input  logic          hold,
    input  logic [AW-1:0] rd_addr,
    output logic [2:0]    rd_data,
    output logic          frame_done,
    output logic          frame_error,
    output logic [15:0]   frame_count,
    output logic [15:0]   frame_checksum
);

    typedef enum logic {
        WAIT_SOP,
        RECEIVE
    } state_t;

    localparam logic [AW-1:0] LastIdx = AW'(NumPixels - 1);

    state_t        state;
    logic [AW-1:0] pixel_index;
    logic [2:0]    pixel_q;
    logic          accept;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          good_frame;
    logic [2:0]    mem [NumPixels];

    assign ready   = reset_n & ~hold;
    assign accept  = valid & ready;
    assign pixel_q = {data[29], data[19], data[9]};

    // Every accepted beat is stored except stray non-SOP beats while waiting for a frame.
    always_comb begin
        wr_en   = accept & ((state == RECEIVE) | startofpacket);
        wr_addr = startofpacket ? '0 : pixel_index;
    end

    always_comb begin
        good_frame = 1'b0;
        if (accept) begin
            if (state == WAIT_SOP)
                good_frame = startofpacket & endofpacket & (NumPixels == 1);
            else
                good_frame = ~startofpacket & endofpacket & (pixel_index == LastIdx);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= pixel_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            rd_data <= '0;
        else
            rd_data <= mem[rd_addr];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= WAIT_SOP;
            pixel_index <= '0;
            frame_done  <= 1'b0;
            frame_error <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_done <= 1'b0;
            if (good_frame) begin
                frame_done  <= 1'b1;
                frame_count <= frame_count + 16'd1;
                pixel_index <= '0;
                state       <= WAIT_SOP;
                if (state == WAIT_SOP)
                    frame_error <= 1'b0;
            end else if (accept) begin
                case (state)
                    WAIT_SOP: begin
                        if (startofpacket) begin
                            if (endofpacket) begin
                                frame_error <= 1'b1;
                                pixel_index <= '0;
                            end else begin
                                frame_error <= 1'b0;
                                pixel_index <= AW'(1);
                                state       <= RECEIVE;
                            end
                        end
                    end
                    RECEIVE: begin
                        // A SOP mid-frame restarts the capture but keeps the error visible.
                        if (startofpacket) begin
                            frame_error <= 1'b1;
                            if (endofpacket) begin
                                pixel_index <= '0;
                                state       <= WAIT_SOP;
                            end else begin
                                pixel_index <= AW'(1);
                            end
                        end else if (endofpacket || pixel_index == LastIdx) begin
                            frame_error <= 1'b1;
                            pixel_index <= '0;
                            state       <= WAIT_SOP;
                        end else begin
                            pixel_index <= pixel_index + AW'(1);
                        end
                    end
                    default: state <= WAIT_SOP;
                endcase
            end
        end
    end

`ifdef FRAME_CHECKSUM_EN
    logic [15:0] running_sum;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            running_sum    <= '0;
            frame_checksum <= '0;
        end else begin
            if (accept && startofpacket)
                running_sum <= {13'd0, pixel_q};
            else if (accept && state == RECEIVE)
                running_sum <= running_sum + {13'd0, pixel_q};
            if (good_frame)
                frame_checksum <= (startofpacket ? 16'd0 : running_sum) + {13'd0, pixel_q};
        end
    end
`else
    assign frame_checksum = '0;
`endif

endmodule
